// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types and constants for the register scoreboard
package scoreboard_pkg;

    localparam int SB_TAG_W    = 3;
    localparam int SB_ALU_LAT  = 1;
    localparam int SB_LOAD_LAT = 2;
    localparam int SB_CNT_W    = $clog2(SB_LOAD_LAT + 1);
    localparam int SB_NREGS    = 32;

    typedef logic [SB_TAG_W-1:0] sb_tag_t;
    typedef logic [SB_CNT_W-1:0] sb_cnt_t;
    typedef logic [4:0]          sb_reg_t;

    typedef struct packed {
        logic    busy;
        logic    is_load;
        sb_cnt_t cnt;
        sb_tag_t tag;
    } sb_entry_t;

    localparam sb_cnt_t SB_ALU_CNT  = sb_cnt_t'(SB_ALU_LAT);
    localparam sb_cnt_t SB_LOAD_CNT = sb_cnt_t'(SB_LOAD_LAT);

    // A source operand only matters when it is actually read and is not x0.
    function automatic logic src_pending(input logic use_rs, input sb_reg_t rs,
                                         input logic [SB_NREGS-1:0] vec);
        return use_rs && (rs != 5'd0) && vec[rs];
    endfunction

endpackage

// File: rtl/scoreboard_if.sv
// rtl/scoreboard_if.sv - issue, writeback, ID-operand and hazard signals of the scoreboard
interface scoreboard_if;
    import scoreboard_pkg::*;

    logic    iss0_fire, iss0_we, iss0_load;
    sb_reg_t iss0_rd;
    logic    iss1_fire, iss1_we, iss1_load;
    sb_reg_t iss1_rd;
    sb_tag_t iss0_tag, iss1_tag;

    logic    wb0_valid, wb1_valid;
    sb_reg_t wb0_rd, wb1_rd;
    sb_tag_t wb0_tag, wb1_tag;

    logic    ex_st_valid;
    sb_reg_t ex_st_rs2;
    logic    flush;

    sb_reg_t id0_rs1, id0_rs2, id0_rd;
    logic    id0_use_rs1, id0_use_rs2, id0_we;
    sb_reg_t id1_rs1, id1_rs2, id1_rd;
    logic    id1_use_rs1, id1_use_rs2, id1_we;

    logic    raw_hazard0, waw_hazard0, war_hazard0, load_use0;
    logic    raw_hazard1, waw_hazard1, war_hazard1, load_use1;

    modport master (
        output iss0_fire, iss0_we, iss0_load, iss0_rd,
        output iss1_fire, iss1_we, iss1_load, iss1_rd,
        output wb0_valid, wb0_rd, wb0_tag, wb1_valid, wb1_rd, wb1_tag,
        output ex_st_valid, ex_st_rs2, flush,
        output id0_rs1, id0_rs2, id0_rd, id0_use_rs1, id0_use_rs2, id0_we,
        output id1_rs1, id1_rs2, id1_rd, id1_use_rs1, id1_use_rs2, id1_we,
        input  iss0_tag, iss1_tag,
        input  raw_hazard0, waw_hazard0, war_hazard0, load_use0,
        input  raw_hazard1, waw_hazard1, war_hazard1, load_use1
    );

    modport slave (
        input  iss0_fire, iss0_we, iss0_load, iss0_rd,
        input  iss1_fire, iss1_we, iss1_load, iss1_rd,
        input  wb0_valid, wb0_rd, wb0_tag, wb1_valid, wb1_rd, wb1_tag,
        input  ex_st_valid, ex_st_rs2, flush,
        input  id0_rs1, id0_rs2, id0_rd, id0_use_rs1, id0_use_rs2, id0_we,
        input  id1_rs1, id1_rs2, id1_rd, id1_use_rs1, id1_use_rs2, id1_we,
        output iss0_tag, iss1_tag,
        output raw_hazard0, waw_hazard0, war_hazard0, load_use0,
        output raw_hazard1, waw_hazard1, war_hazard1, load_use1
    );
endinterface

// File: rtl/scoreboard_entry.sv
// rtl/scoreboard_entry.sv - in-flight producer state for one architectural register
module scoreboard_entry
    import scoreboard_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    iss0_hit,
    input  logic    iss0_load,
    input  sb_tag_t iss0_tag,
    input  logic    iss1_hit,
    input  logic    iss1_load,
    input  sb_tag_t iss1_tag,
    input  logic    wb0_hit,
    input  sb_tag_t wb0_tag,
    input  logic    wb1_hit,
    input  sb_tag_t wb1_tag,
    output logic    pend_alu,
    output logic    pend_load
);

    sb_entry_t entry;
    logic      wb_clr;
    logic      live;

    // Only the writeback of the youngest producer (matching tag) retires the entry.
    assign wb_clr = entry.busy &&
                    ((wb0_hit && (wb0_tag == entry.tag)) ||
                     (wb1_hit && (wb1_tag == entry.tag)));

    // A same-cycle matching writeback already bypasses, so it hides the entry.
    assign live      = entry.busy && !wb_clr && (entry.cnt != '0);
    assign pend_alu  = live && !entry.is_load;
    assign pend_load = live && entry.is_load;

    // Entry update: flush > slot1 issue > slot0 issue > writeback clear > countdown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry <= '0;
        end else if (flush) begin
            entry <= '0;
        end else if (iss1_hit) begin
            entry <= '{busy: 1'b1, is_load: iss1_load,
                       cnt: (iss1_load ? SB_LOAD_CNT : SB_ALU_CNT), tag: iss1_tag};
        end else if (iss0_hit) begin
            entry <= '{busy: 1'b1, is_load: iss0_load,
                       cnt: (iss0_load ? SB_LOAD_CNT : SB_ALU_CNT), tag: iss0_tag};
        end else if (wb_clr) begin
            entry.busy <= 1'b0;
        end else if (entry.busy && (entry.cnt != '0)) begin
            entry.cnt <= entry.cnt - sb_cnt_t'(1);
        end
    end

endmodule

// File: rtl/scoreboard.sv
// rtl/scoreboard.sv - per-register producer tracker driving issue hazards for both ID slots
module scoreboard
    import scoreboard_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    scoreboard_if.slave  sb
);

    sb_tag_t             ctr;
    logic [SB_NREGS-1:0] pend_alu;
    logic [SB_NREGS-1:0] pend_load;
    logic [SB_NREGS-1:0] pend_any;

    assign sb.iss0_tag = ctr;
    assign sb.iss1_tag = ctr + sb_tag_t'(1);

    // Tag counter advances by the number of instructions issued this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctr <= '0;
        end else if (sb.flush) begin
            ctr <= '0;
        end else begin
            ctr <= ctr + sb_tag_t'(sb.iss0_fire) + sb_tag_t'(sb.iss1_fire);
        end
    end

    // x0 is hard-wired and never has a producer in flight.
    assign pend_alu[0]  = 1'b0;
    assign pend_load[0] = 1'b0;

    for (genvar i = 1; i < SB_NREGS; i++) begin : g_ent
        scoreboard_entry u_ent (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (sb.flush),
            .iss0_hit  (sb.iss0_fire && sb.iss0_we && (sb.iss0_rd == 5'(i))),
            .iss0_load (sb.iss0_load),
            .iss0_tag  (sb.iss0_tag),
            .iss1_hit  (sb.iss1_fire && sb.iss1_we && (sb.iss1_rd == 5'(i))),
            .iss1_load (sb.iss1_load),
            .iss1_tag  (sb.iss1_tag),
            .wb0_hit   (sb.wb0_valid && (sb.wb0_rd == 5'(i))),
            .wb0_tag   (sb.wb0_tag),
            .wb1_hit   (sb.wb1_valid && (sb.wb1_rd == 5'(i))),
            .wb1_tag   (sb.wb1_tag),
            .pend_alu  (pend_alu[i]),
            .pend_load (pend_load[i])
        );
    end

    assign pend_any = pend_alu | pend_load;

    assign sb.raw_hazard0 = src_pending(sb.id0_use_rs1, sb.id0_rs1, pend_alu) ||
                            src_pending(sb.id0_use_rs2, sb.id0_rs2, pend_alu);
    assign sb.load_use0   = src_pending(sb.id0_use_rs1, sb.id0_rs1, pend_load) ||
                            src_pending(sb.id0_use_rs2, sb.id0_rs2, pend_load);
    assign sb.waw_hazard0 = src_pending(sb.id0_we, sb.id0_rd, pend_any);
    assign sb.war_hazard0 = sb.id0_we && (sb.id0_rd != 5'd0) && sb.ex_st_valid &&
                            (sb.id0_rd == sb.ex_st_rs2);

    assign sb.raw_hazard1 = src_pending(sb.id1_use_rs1, sb.id1_rs1, pend_alu) ||
                            src_pending(sb.id1_use_rs2, sb.id1_rs2, pend_alu);
    assign sb.load_use1   = src_pending(sb.id1_use_rs1, sb.id1_rs1, pend_load) ||
                            src_pending(sb.id1_use_rs2, sb.id1_rs2, pend_load);
    assign sb.waw_hazard1 = src_pending(sb.id1_we, sb.id1_rd, pend_any);
    assign sb.war_hazard1 = sb.id1_we && (sb.id1_rd != 5'd0) && sb.ex_st_valid &&
                            (sb.id1_rd == sb.ex_st_rs2);

endmodule

// File: tb/tb_scoreboard.sv
// tb/tb_scoreboard.sv - directed scoreboard-checked bench for the register scoreboard
module tb_scoreboard;
    import scoreboard_pkg::*;

    localparam logic [7:0] R0 = 8'h80, L0 = 8'h40, W0 = 8'h20, A0 = 8'h10;
    localparam logic [7:0] R1 = 8'h08, L1 = 8'h04, W1 = 8'h02, A1 = 8'h01;

    typedef struct {
        string      name;
        logic [7:0] haz;
        bit         tchk;
        logic [2:0] t0;
        logic [2:0] t1;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [7:0] obs;

    scoreboard_if bus();

    scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus)
    );

    always #5 clk = ~clk;

    // Monitor: compare every queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            obs = {bus.raw_hazard0, bus.load_use0, bus.waw_hazard0, bus.war_hazard0,
                   bus.raw_hazard1, bus.load_use1, bus.waw_hazard1, bus.war_hazard1};
            checks++;
            if (obs !== mon_e.haz ||
                (mon_e.tchk && (bus.iss0_tag !== mon_e.t0 || bus.iss1_tag !== mon_e.t1))) begin
                failures++;
                $display("FAIL %s: got haz=%b tags=%0d/%0d, required haz=%b tags=%0d/%0d (tags checked=%0d)",
                         mon_e.name, obs, bus.iss0_tag, bus.iss1_tag,
                         mon_e.haz, mon_e.t0, mon_e.t1, mon_e.tchk);
            end
        end
    end

    task automatic idle();
        bus.iss0_fire = 0; bus.iss0_we = 0; bus.iss0_load = 0; bus.iss0_rd = 0;
        bus.iss1_fire = 0; bus.iss1_we = 0; bus.iss1_load = 0; bus.iss1_rd = 0;
        bus.wb0_valid = 0; bus.wb0_rd = 0; bus.wb0_tag = 0;
        bus.wb1_valid = 0; bus.wb1_rd = 0; bus.wb1_tag = 0;
        bus.ex_st_valid = 0; bus.ex_st_rs2 = 0; bus.flush = 0;
        bus.id0_rs1 = 0; bus.id0_rs2 = 0; bus.id0_rd = 0;
        bus.id0_use_rs1 = 0; bus.id0_use_rs2 = 0; bus.id0_we = 0;
        bus.id1_rs1 = 0; bus.id1_rs2 = 0; bus.id1_rd = 0;
        bus.id1_use_rs1 = 0; bus.id1_use_rs2 = 0; bus.id1_we = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic expect_out(input string name, input logic [7:0] haz,
                              input bit tchk, input logic [2:0] t0, input logic [2:0] t1);
        exp_t e;
        e.name = name; e.haz = haz; e.tchk = tchk; e.t0 = t0; e.t1 = t1;
        q.push_back(e);
    endtask

    task automatic iss0(input logic [4:0] rd, input logic we, input logic ld);
        bus.iss0_fire = 1; bus.iss0_rd = rd; bus.iss0_we = we; bus.iss0_load = ld;
    endtask

    task automatic iss1(input logic [4:0] rd, input logic we, input logic ld);
        bus.iss1_fire = 1; bus.iss1_rd = rd; bus.iss1_we = we; bus.iss1_load = ld;
    endtask

    initial begin
        int n;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        expect_out("reset_state", 8'h00, 1, 0, 1);

        // Load-use on x5
        step(); iss0(5, 1, 1); bus.id0_use_rs1 = 1; bus.id0_rs1 = 5;
        expect_out("lu_same_cycle_invisible", 8'h00, 1, 0, 1);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 5; bus.id0_use_rs2 = 1; bus.id0_rs2 = 1;
        bus.id0_we = 1; bus.id0_rd = 6;
        expect_out("lu_cycle1", L0, 1, 1, 2);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 5; bus.id0_use_rs2 = 1; bus.id0_rs2 = 1;
        bus.id0_we = 1; bus.id0_rd = 6;
        expect_out("lu_cycle2", L0, 0, 0, 0);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 5; bus.id0_use_rs2 = 1; bus.id0_rs2 = 1;
        bus.id0_we = 1; bus.id0_rd = 6;
        expect_out("lu_forwardable", 8'h00, 0, 0, 0);

        // Reset in the middle of an outstanding load
        step(); iss0(5, 1, 1);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 5;
        expect_out("lu_reissue", L0, 1, 2, 3);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 5; rst_n = 0;
        expect_out("reset_async", 8'h00, 1, 0, 1);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 5; rst_n = 1;
        expect_out("reset_release", 8'h00, 1, 0, 1);

        // ALU RAW on x7
        step(); iss0(7, 1, 0);
        step(); bus.id0_use_rs2 = 1; bus.id0_rs2 = 7; bus.id1_use_rs1 = 1; bus.id1_rs1 = 7;
        expect_out("raw_alu", R0 | R1, 1, 1, 2);
        step(); bus.id0_use_rs2 = 1; bus.id0_rs2 = 7; bus.id1_use_rs1 = 1; bus.id1_rs1 = 7;
        expect_out("raw_forwardable", 8'h00, 0, 0, 0);

        // Stale writeback on x8: tag 2 then tag 4
        step(); iss0(3, 0, 0); bus.wb0_valid = 1; bus.wb0_rd = 7; bus.wb0_tag = 0;
        step(); iss0(8, 1, 0);
        expect_out("tag_x8_first", 8'h00, 1, 2, 3);
        step(); iss0(3, 0, 0);
        step(); iss0(8, 1, 1);
        expect_out("tag_x8_second", 8'h00, 1, 4, 5);
        step(); bus.wb0_valid = 1; bus.wb0_rd = 8; bus.wb0_tag = 2;
        bus.id0_use_rs1 = 1; bus.id0_rs1 = 8;
        expect_out("stale_wb_not_bypassed", L0, 0, 0, 0);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 8;
        expect_out("stale_wb_kept_busy", L0, 0, 0, 0);
        step(); bus.wb0_valid = 1; bus.wb0_rd = 8; bus.wb0_tag = 4;

        // Dual issue to x9: slot1 (ALU, tag 6) wins over slot0 (load, tag 5)
        step(); iss0(9, 1, 1); iss1(9, 1, 0);
        expect_out("dual_tags", 8'h00, 1, 5, 6);
        step(); bus.wb0_valid = 1; bus.wb0_rd = 9; bus.wb0_tag = 5;
        bus.id1_we = 1; bus.id1_rd = 9; bus.id1_use_rs1 = 1; bus.id1_rs1 = 9;
        expect_out("dual_waw_tag_wrap", R1 | W1, 1, 7, 0);
        step(); bus.id1_we = 1; bus.id1_rd = 9; bus.id1_use_rs1 = 1; bus.id1_rs1 = 9;
        expect_out("dual_waw_done", 8'h00, 1, 7, 0);

        // WAR against a store in EX
        step(); bus.ex_st_valid = 1; bus.ex_st_rs2 = 10; bus.id1_we = 1; bus.id1_rd = 10;
        expect_out("war_slot1", A1, 0, 0, 0);
        step(); bus.ex_st_valid = 1; bus.ex_st_rs2 = 0; bus.id1_we = 1; bus.id1_rd = 0;
        bus.id0_we = 1; bus.id0_rd = 10;
        expect_out("war_x0", 8'h00, 0, 0, 0);
        step(); bus.ex_st_valid = 0; bus.ex_st_rs2 = 10; bus.id0_we = 1; bus.id0_rd = 10;
        expect_out("war_no_store", 8'h00, 0, 0, 0);
        step(); bus.ex_st_valid = 1; bus.ex_st_rs2 = 10; bus.id0_we = 1; bus.id0_rd = 10;
        bus.id1_rd = 10;
        expect_out("war_slot0", A0, 0, 0, 0);

        // Flush with loads in flight on x13..x16 and a same-cycle issue to x17
        step(); iss0(13, 1, 1); iss1(14, 1, 1);
        expect_out("flush_pre_tags", 8'h00, 1, 7, 0);
        step(); iss0(15, 1, 1); iss1(16, 1, 1);
        step(); bus.flush = 1; iss0(17, 1, 1);
        bus.id0_use_rs1 = 1; bus.id0_rs1 = 13; bus.id0_use_rs2 = 1; bus.id0_rs2 = 15;
        bus.id1_use_rs1 = 1; bus.id1_rs1 = 16; bus.id1_we = 1; bus.id1_rd = 14;
        expect_out("flush_pre_hazards", L0 | L1 | W1, 1, 3, 4);
        step();
        bus.id0_use_rs1 = 1; bus.id0_rs1 = 15; bus.id0_use_rs2 = 1; bus.id0_rs2 = 17;
        bus.id1_use_rs1 = 1; bus.id1_rs1 = 16; bus.id1_we = 1; bus.id1_rd = 14;
        expect_out("flush_cleared", 8'h00, 1, 0, 1);

        // Same-cycle writeback bypass on x12, then persistent clear
        step(); iss0(12, 1, 1);
        step(); bus.wb1_valid = 1; bus.wb1_rd = 12; bus.wb1_tag = 0;
        bus.id0_use_rs2 = 1; bus.id0_rs2 = 12; bus.id1_use_rs1 = 1; bus.id1_rs1 = 12;
        expect_out("wb_bypass", 8'h00, 1, 1, 2);
        step(); bus.id0_use_rs2 = 1; bus.id0_rs2 = 12; bus.id1_use_rs1 = 1; bus.id1_rs1 = 12;
        expect_out("wb_cleared", 8'h00, 0, 0, 0);

        // x0 never becomes busy
        step(); iss0(0, 1, 1); iss1(0, 1, 0);
        step(); bus.id0_use_rs1 = 1; bus.id0_rs1 = 0; bus.id0_we = 1; bus.id0_rd = 0;
        bus.id1_use_rs2 = 1; bus.id1_rs2 = 0;
        expect_out("x0_never_busy", 8'h00, 1, 3, 4);

        step();
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
